// File: rtl/id_ex_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_pipe_stage                                                          |
// | ID->EX pipeline register: valid/ready handshake, 2-entry skid, flush.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module id_ex_pipe_stage #(
  parameter int PC_W   = 8,
  parameter int REG_W  = 3,
  parameter int IMM_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   PC_IF_ID,
  input  logic [REG_W-1:0]  RegRd_IF_ID,
  input  logic [IMM_W-1:0]  imm_ImmGen,
  input  logic [IMM_W-1:0]  relAdd_ImmGen,
  input  logic              RegWrite_ctrl,
  input  logic              jumpIns_ctrl,
  input  logic              valueToReg_ctrl,
  input  logic [DATA_W-1:0] Data1_Regfile,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   PC_ID_EX,
  output logic [REG_W-1:0]  RegRd_ID_EX,
  output logic [IMM_W-1:0]  imm_ID_EX,
  output logic [IMM_W-1:0]  relAdd_ID_EX,
  output logic [DATA_W-1:0] Data1_ID_EX,
  output logic              RegWrite_ID_EX,
  output logic              jumpIns_ID_EX,
  output logic              valueToReg_ID_EX,
  output logic [1:0]        occupancy
);

  localparam int c_ENT_W = PC_W + REG_W + 2*IMM_W + DATA_W + 3;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_ENT_W-1:0] r_m;
  logic [c_ENT_W-1:0] r_s;
  logic [c_ENT_W-1:0] w_in;
  logic               r_in_ready;
  logic               w_acc;
  logic               w_deq;
  logic               w_m_valid;
  logic               w_load_m_in;
  logic               w_load_m_s;
  logic               w_load_s_in;
  logic               w_rw;
  logic               w_jmp;
  logic               w_v2r;

  assign w_in = {PC_IF_ID, RegRd_IF_ID, imm_ImmGen, relAdd_ImmGen, Data1_Regfile,
                 RegWrite_ctrl, jumpIns_ctrl, valueToReg_ctrl};

  assign w_m_valid = (r_state != EMPTY);
  assign w_acc     = in_valid & r_in_ready;
  assign w_deq     = w_m_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_m_in = 1'b0;
    w_load_m_s  = 1'b0;
    w_load_s_in = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            w_load_m_in = 1'b1;
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          if (w_acc && w_deq) begin
            w_load_m_in = 1'b1;
          end else if (w_acc) begin
            w_load_s_in = 1'b1;
            w_state_nxt = FULL;
          end else if (w_deq) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (w_deq) begin
            w_load_m_s  = 1'b1;
            w_state_nxt = ONE;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // in_ready is a register so that decode never sees a combinational path from out_ready.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
      r_m        <= '0;
      r_s        <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != FULL);
      if (w_load_m_in) begin
        r_m <= w_in;
      end else if (w_load_m_s) begin
        r_m <= r_s;
      end
      if (w_load_s_in) begin
        r_s <= w_in;
      end
    end
  end

  assign {PC_ID_EX, RegRd_ID_EX, imm_ID_EX, relAdd_ID_EX, Data1_ID_EX,
          w_rw, w_jmp, w_v2r} = r_m;

  assign in_ready         = r_in_ready;
  assign out_valid        = w_m_valid;
  assign RegWrite_ID_EX   = w_rw  & w_m_valid;
  assign jumpIns_ID_EX    = w_jmp & w_m_valid;
  assign valueToReg_ID_EX = w_v2r & w_m_valid;
  assign occupancy        = r_state;

endmodule
`default_nettype wire
